// File: rtl/uart_tx_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg : UART register map, CONF bit positions and arbiter FSM states. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int c_UART_DATA_OFS = 'h0;
  localparam int c_UART_CONF_OFS = 'h4;

  localparam int c_CONF_RX_FULL  = 2;
  localparam int c_CONF_RX_EMPTY = 3;
  localparam int c_CONF_TX_FULL  = 4;
  localparam int c_CONF_TX_EMPTY = 5;
  localparam int c_CONF_RX_ERR   = 31;

  localparam logic [1:0] c_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POLL_AR = 3'd1,
    ST_POLL_R  = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_B    = 3'd4
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | axi4_lite : AXI4-Lite channel bundle with master/slave modports.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface axi4_lite #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 3
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH/8-1:0]      wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [WIDTH-1:0]        rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer advances on accept.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter  int N_REQ  = 4,
  localparam int c_ID_W = $clog2(N_REQ)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [N_REQ-1:0]  req,
  input  wire logic              accept,
  output logic      [N_REQ-1:0]  grant,
  output logic      [c_ID_W-1:0] grant_idx
);

  logic [c_ID_W-1:0] r_ptr;
  logic [c_ID_W:0]   w_sum;
  logic [c_ID_W-1:0] w_cand;
  logic              w_found;

  // Scan from the pointer upward, wrapping modulo N_REQ; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + (c_ID_W+1)'(off);
      if (w_sum >= (c_ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (c_ID_W+1)'(N_REQ);
      end
      w_cand = w_sum[c_ID_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= (grant_idx == c_ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter : grants byte requesters round-robin and pushes each     |
// | byte to an AXI4-Lite UART after polling CONF.TX_FULL.   Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int ADDR_WIDTH = 3,
  parameter  int N_REQ      = 4,
  localparam int c_ID_W     = $clog2(N_REQ),
  localparam int c_STRB_W   = WIDTH / 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [N_REQ-1:0]      req_valid,
  input  wire logic [N_REQ-1:0][7:0] req_data,
  output logic      [N_REQ-1:0]      req_ready,
  output logic                       busy,
  output logic      [c_ID_W-1:0]     grant_id,
  output logic                       err,
  axi4_lite.master                   axi
);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [7:0]        r_byte;
  logic [c_ID_W-1:0] r_grant_id;
  logic              r_err;
  logic              r_aw_done;
  logic              r_w_done;

  logic [N_REQ-1:0]  w_gnt;
  logic [c_ID_W-1:0] w_gnt_idx;
  logic              w_accept;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_r_bad;
  logic              w_b_bad;

  assign w_accept = (r_state == ST_IDLE) && (|req_valid);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (w_accept),
    .grant     (w_gnt),
    .grant_idx (w_gnt_idx)
  );

  // Every valid is a pure decode of registered state, so rst drops it next edge.
  assign axi.arvalid = (r_state == ST_POLL_AR);
  assign axi.araddr  = ADDR_WIDTH'(c_UART_CONF_OFS);
  assign axi.arprot  = 3'b000;
  assign axi.rready  = (r_state == ST_POLL_R);
  assign axi.awvalid = (r_state == ST_WR) && !r_aw_done;
  assign axi.awaddr  = ADDR_WIDTH'(c_UART_DATA_OFS);
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = (r_state == ST_WR) && !r_w_done;
  assign axi.wdata   = {{(WIDTH-8){1'b0}}, r_byte};
  assign axi.wstrb   = c_STRB_W'(1);
  assign axi.bready  = (r_state == ST_WR_B);

  assign w_aw_hs = axi.awvalid && axi.awready;
  assign w_w_hs  = axi.wvalid && axi.wready;
  assign w_r_bad = axi.rvalid && (axi.rresp != c_RESP_OKAY);
  assign w_b_bad = axi.bvalid && (axi.bresp != c_RESP_OKAY);

  assign req_ready = w_accept ? w_gnt : '0;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant_id;
  assign err       = r_err;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_POLL_AR;
      end
      ST_POLL_AR: begin
        if (axi.arready) w_state_next = ST_POLL_R;
      end
      ST_POLL_R: begin
        if (axi.rvalid) begin
          if (w_r_bad || axi.rdata[c_CONF_TX_FULL]) w_state_next = ST_POLL_AR;
          else                                      w_state_next = ST_WR;
        end
      end
      ST_WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = ST_WR_B;
      end
      ST_WR_B: begin
        if (axi.bvalid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_grant_id <= '0;
      r_err      <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_byte     <= req_data[w_gnt_idx];
        r_grant_id <= w_gnt_idx;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == ST_POLL_R && w_r_bad) || (r_state == ST_WR_B && w_b_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed bench with an AXI4-Lite UART slave model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_ready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            err;

  axi4_lite #(.WIDTH(32), .ADDR_WIDTH(3)) axi ();

  uart_tx_arbiter #(.WIDTH(32), .ADDR_WIDTH(3), .N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- UART slave model: 4-deep TX FIFO, serial drain ----------
  int         aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic       aw_got, w_got, bresp_err = 1'b0, drain_en = 1'b1;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;
  logic [2:0]  aw_addr_s;
  int         n_ar = 0, n_full = 0, n_aw = 0, n_w = 0, drain_cnt = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  int         proto_viol = 0, ready_viol = 0, aw_only = 0;
  int         gnt_log[$];

  assign axi.arready = 1'b1;
  assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_delay);

  always @(posedge clk) begin
    if (rst) begin
      axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rresp  <= 2'b00;
        axi.rdata  <= (fifo_q.size() >= 4) ? 32'h0000_0010 : 32'h0000_0020;
        n_ar++;
        if (fifo_q.size() >= 4) n_full++;
      end else if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
      end
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1; aw_addr_s <= axi.awaddr; aw_cnt <= 0; n_aw++;
      end else if (axi.awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1; w_data_s <= axi.wdata; w_strb_s <= axi.wstrb; w_cnt <= 0; n_w++;
      end else if (axi.wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_err ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
        wr_data_q.push_back(w_data_s);
        wr_strb_q.push_back(w_strb_s);
        if (aw_addr_s != 3'h0) proto_viol++;
        fifo_q.push_back(w_data_s[7:0]);
      end else if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end
    end
    drain_cnt++;
    if (drain_en && fifo_q.size() > 0 && drain_cnt >= 2) begin
      tx_q.push_back(fifo_q.pop_front());
      drain_cnt = 0;
    end
  end

  // ---------------- protocol / requester monitors --------------------------
  logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rst, p_rdy;

  always @(posedge clk) begin
    if (!rst && !p_rst) begin
      if (p_arv && !p_arr && !axi.arvalid) proto_viol++;
      if (p_awv && !p_awr && !axi.awvalid) proto_viol++;
      if (p_wv && !p_wr && !axi.wvalid) proto_viol++;
    end
    if ((axi.arvalid || axi.rready) && (axi.awvalid || axi.wvalid || axi.bready)) proto_viol++;
    if (axi.arvalid && (axi.araddr != 3'h4 || axi.arprot != 3'h0)) proto_viol++;
    if (axi.awvalid && axi.awprot != 3'h0) proto_viol++;
    if (axi.awvalid && !axi.wvalid) aw_only++;
    if (req_ready != 4'b0) begin
      if (!$onehot(req_ready) || p_rdy) ready_viol++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gnt_log.push_back(i);
    end
    p_arv <= axi.arvalid; p_arr <= axi.arready;
    p_awv <= axi.awvalid; p_awr <= axi.awready;
    p_wv  <= axi.wvalid;  p_wr  <= axi.wready;
    p_rst <= rst;         p_rdy <= (req_ready != 4'b0);
  end

  // ---------------- stimulus helpers ---------------------------------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic send(input logic [3:0] mask, input logic [3:0][7:0] data,
                      output logic [3:0] got_ready, output logic [1:0] got_id);
    bit ok = 1'b0;
    req_data  = data;
    req_valid = mask;
    got_ready = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 4'b0) begin got_ready = req_ready; ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL grant_timeout: got no req_ready, expected one within 40 cycles");
    end
    @(posedge clk); #1;
    got_id    = grant_id;
    req_valid = '0;
    req_data  = {4{8'hEE}};
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    n_checks++; n_err++;
    $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][7:0] data;
    logic [1:0]      exp_id;
    logic [7:0]      exp_byte;
  } vec_t;

  vec_t vecs[8];
  logic [3:0][7:0] base;
  logic [3:0] gr;
  logic [1:0] gid;
  int mark, ar0, f0, aw0, w0;
  int exp_ord[5];

  initial begin
    base = {8'h13, 8'h12, 8'h11, 8'h10};
    vecs[0] = '{4'b0100, {8'h13, 8'hA5, 8'h11, 8'h10}, 2'd2, 8'hA5};
    vecs[1] = '{4'b1111, base, 2'd3, 8'h13};
    vecs[2] = '{4'b1111, base, 2'd0, 8'h10};
    vecs[3] = '{4'b1111, base, 2'd1, 8'h11};
    vecs[4] = '{4'b0011, base, 2'd0, 8'h10};
    vecs[5] = '{4'b1001, base, 2'd3, 8'h13};
    vecs[6] = '{4'b0010, base, 2'd1, 8'h11};
    vecs[7] = '{4'b0101, base, 2'd2, 8'h12};
    exp_ord = '{0, 1, 2, 3, 0};

    req_valid = '0;
    req_data  = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_err", err, 0);
    check("reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: round-robin order from reset pointer, single-write per grant.
    foreach (vecs[k]) begin
      ar0  = n_ar;
      mark = wr_data_q.size();
      send(vecs[k].mask, vecs[k].data, gr, gid);
      check($sformatf("v%0d_req_ready", k), gr, 4'b0001 << vecs[k].exp_id);
      check($sformatf("v%0d_grant_id", k), gid, vecs[k].exp_id);
      wait_idle(40);
      check($sformatf("v%0d_writes", k), wr_data_q.size() - mark, 1);
      check($sformatf("v%0d_wdata", k), wr_data_q[$], {24'h0, vecs[k].exp_byte});
      check($sformatf("v%0d_wstrb", k), wr_strb_q[$], 4'b0001);
      if (k == 0) begin
        check("v0_conf_reads", n_ar - ar0, 1);
        check("v0_err", err, 0);
        repeat (6) @(posedge clk); #1;
        check("v0_tx_byte", tx_q[$], 8'hA5);
      end
    end

    // All four requesters held valid: grant order 0,1,2,3,0 from reset.
    do_reset();
    gnt_log.delete();
    mark = wr_data_q.size();
    req_data  = base;
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && gnt_log.size() < 5; c++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("cont_grants", gnt_log.size(), 5);
    wait_idle(40);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("cont_gnt%0d", k), (gnt_log.size() > k) ? gnt_log[k] : -1, exp_ord[k]);
      check($sformatf("cont_wdata%0d", k),
            (wr_data_q.size() > mark + k) ? wr_data_q[mark + k] : 32'hFFFF_FFFF,
            32'h10 + exp_ord[k]);
    end

    // TX FIFO fills: fifth byte must wait on CONF polling with no timeout.
    repeat (20) @(posedge clk); #1;
    drain_en = 1'b0;
    mark = wr_data_q.size();
    for (int k = 0; k < 4; k++) begin
      send(4'b0001, {24'h0, 8'h30 + 8'(k)}, gr, gid);
      wait_idle(40);
    end
    f0 = n_full;
    send(4'b0001, {24'h0, 8'h34}, gr, gid);
    repeat (30) @(posedge clk); #1;
    check("full_writes_held", wr_data_q.size() - mark, 4);
    check("full_busy", busy, 1);
    check("full_polls", (n_full - f0) >= 5, 1);
    drain_en = 1'b1;
    wait_idle(100);
    check("full_writes_done", wr_data_q.size() - mark, 5);
    repeat (30) @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("full_tx%0d", k), tx_q[tx_q.size() - 5 + k], 8'h30 + 8'(k));
    end

    // SLVERR on write response: err sticky, next request still served.
    check("pre_err", err, 0);
    bresp_err = 1'b1;
    send(4'b0010, {8'h0, 8'h0, 8'h55, 8'h0}, gr, gid);
    wait_idle(40);
    bresp_err = 1'b0;
    check("slverr_err", err, 1);
    check("slverr_idle", busy, 0);
    mark = wr_data_q.size();
    send(4'b0100, {8'h0, 8'h66, 8'h0, 8'h0}, gr, gid);
    wait_idle(40);
    check("slverr_next_write", wr_data_q.size() - mark, 1);
    check("slverr_next_wdata", wr_data_q[$], 32'h66);
    check("slverr_sticky", err, 1);

    // awready three cycles behind wready: wvalid drops alone, one write.
    aw_delay = 3;
    aw_only = 0; aw0 = n_aw; w0 = n_w;
    mark = wr_data_q.size();
    send(4'b1000, {8'h77, 8'h0, 8'h0, 8'h0}, gr, gid);
    wait_idle(40);
    aw_delay = 0;
    check("awdly_aw_only_cycles", aw_only, 3);
    check("awdly_aw_hs", n_aw - aw0, 1);
    check("awdly_w_hs", n_w - w0, 1);
    check("awdly_writes", wr_data_q.size() - mark, 1);
    check("awdly_wdata", wr_data_q[$], 32'h77);

    // Reset while the write is stalled: abandon, then requester 0 first.
    aw_delay = 20; w_delay = 20;
    mark = wr_data_q.size();
    send(4'b1000, {8'h88, 8'h0, 8'h0, 8'h0}, gr, gid);
    check("rstwr_grant_id", gid, 3);
    for (int c = 0; c < 20 && !axi.awvalid; c++) begin
      @(posedge clk); #1;
    end
    check("rstwr_in_wr", axi.awvalid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstwr_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
    check("rstwr_busy", busy, 0);
    check("rstwr_gid", grant_id, 0);
    check("rstwr_err", err, 0);
    rst = 1'b0;
    aw_delay = 0; w_delay = 0;
    @(posedge clk); #1;
    check("rstwr_abandoned", wr_data_q.size() - mark, 0);
    send(4'b1111, base, gr, gid);
    check("rstwr_first_ready", gr, 4'b0001);
    check("rstwr_first_id", gid, 0);
    wait_idle(40);
    check("rstwr_first_wdata", wr_data_q[$], 32'h10);

    check("axi_protocol", proto_viol, 0);
    check("req_ready_onehot_pulse", ready_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
